// File: rtl/aes_word_sequencer.sv
// rtl/aes_word_sequencer.sv - packs four 32-bit words into an AES block, runs the core, unpacks the result
// The timeout abort keeps a hung core from wedging the stream; the block is dropped and load restarts.
module aes_word_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_mode,
  output logic         core_start,
  output logic         core_enc_dec,
  output logic [127:0] core_data_in,
  input  logic [127:0] core_data_out,
  input  logic         core_done,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [31:0]  m_data,
  output logic         m_last,
  output logic         busy,
  output logic         timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} state_t;

  state_t         state, state_nxt;
  logic [1:0]     word_cnt;
  logic [CW-1:0]  wait_cnt;
  logic [127:0]   result;
  logic           s_acc;
  logic           m_hs;
  logic           wait_expired;

  assign s_acc        = (state == LOAD) && s_valid && s_ready;
  assign m_hs         = (state == DRAIN) && m_valid && m_ready;
  assign wait_expired = (wait_cnt == CW'(TIMEOUT - 1));

  function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] idx);
    case (idx)
      2'd0:    word_sel = blk[127:96];
      2'd1:    word_sel = blk[95:64];
      2'd2:    word_sel = blk[63:32];
      default: word_sel = blk[31:0];
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    core_start = 1'b0;
    busy       = (state != LOAD);
    case (state)
      LOAD:  if (s_acc && word_cnt == 2'd3) state_nxt = START;
      START: begin
        core_start = 1'b1;
        state_nxt  = WAIT;
      end
      // core_done is checked first so a completion on the last allowed cycle still counts
      WAIT: begin
        if (core_done)         state_nxt = DRAIN;
        else if (wait_expired) state_nxt = LOAD;
      end
      DRAIN: if (m_hs && word_cnt == 2'd3) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // word_cnt doubles as the load slot index and the drain word index; both wrap at 3
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_ready      <= 1'b0;
      word_cnt     <= 2'd0;
      wait_cnt     <= '0;
      core_enc_dec <= 1'b0;
      core_data_in <= '0;
      result       <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_last       <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      s_ready <= (state_nxt == LOAD);

      if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      else               wait_cnt <= '0;

      if (s_acc) begin
        case (word_cnt)
          2'd0:    core_data_in[127:96] <= s_data;
          2'd1:    core_data_in[95:64]  <= s_data;
          2'd2:    core_data_in[63:32]  <= s_data;
          default: core_data_in[31:0]   <= s_data;
        endcase
        word_cnt <= word_cnt + 2'd1;
        if (word_cnt == 2'd0) begin
          core_enc_dec <= s_mode;
          timeout_err  <= 1'b0;
        end
      end

      if (state == WAIT) begin
        if (core_done) begin
          result  <= core_data_out;
          m_valid <= 1'b1;
          m_data  <= core_data_out[127:96];
          m_last  <= 1'b0;
        end else if (wait_expired) begin
          timeout_err  <= 1'b1;
          core_data_in <= '0;
        end
      end

      if (m_hs) begin
        word_cnt <= word_cnt + 2'd1;
        if (word_cnt == 2'd3) begin
          m_valid <= 1'b0;
          m_last  <= 1'b0;
        end else begin
          m_data <= word_sel(result, word_cnt + 2'd1);
          m_last <= (word_cnt == 2'd2);
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_word_sequencer.sv
// tb/tb_aes_word_sequencer.sv - directed self-checking bench for aes_word_sequencer
module tb_aes_word_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         s_mode;
  logic         core_start;
  logic         core_enc_dec;
  logic [127:0] core_data_in;
  logic [127:0] core_data_out;
  logic         core_done;
  logic         m_valid;
  logic         m_ready;
  logic [31:0]  m_data;
  logic         m_last;
  logic         busy;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;
  int hs;
  logic [31:0] exp_w [4];

  aes_word_sequencer #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_mode(s_mode), .core_start(core_start), .core_enc_dec(core_enc_dec),
    .core_data_in(core_data_in), .core_data_out(core_data_out), .core_done(core_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic m);
    s_valid = 1'b1;
    s_data  = d;
    s_mode  = m;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; s_valid = 1'b0; s_data = '0; s_mode = 1'b0;
    core_data_out = '0; core_done = 1'b0; m_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_core_start", core_start, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_data_in", core_data_in, 0);
    reset = 1'b1;
    @(negedge clk);
    check("s_ready_after_rst", s_ready, 1);

    // encrypt block, core done after 4 cycles, m_ready held high
    send_word(32'h00112233, 1'b0);
    send_word(32'h44556677, 1'b0);
    send_word(32'h8899AABB, 1'b0);
    send_word(32'hCCDDEEFF, 1'b0);
    check("start_pulse", core_start, 1);
    check("start_data_in", core_data_in, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    check("start_enc_dec", core_enc_dec, 0);
    check("start_s_ready", s_ready, 0);
    check("start_busy", busy, 1);
    @(negedge clk);
    check("wait_no_start", core_start, 0);
    s_valid = 1'b1; s_data = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    check("wait_data_stable", core_data_in, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    s_valid = 1'b0;
    core_done = 1'b1; core_data_out = 128'h11223344_55667788_99AABBCC_DDEEFF00; m_ready = 1'b1;
    @(negedge clk);
    core_done = 1'b0; core_data_out = '0;
    check("drain_valid", m_valid, 1);
    check("drain_w0", m_data, 32'h11223344);
    check("drain_l0", m_last, 0);
    @(negedge clk);
    check("drain_w1", m_data, 32'h55667788);
    check("drain_l1", m_last, 0);
    @(negedge clk);
    check("drain_w2", m_data, 32'h99AABBCC);
    check("drain_l2", m_last, 0);
    @(negedge clk);
    check("drain_w3", m_data, 32'hDDEEFF00);
    check("drain_l3", m_last, 1);
    @(negedge clk);
    check("post_drain_valid", m_valid, 0);
    check("post_drain_s_ready", s_ready, 1);
    check("post_drain_busy", busy, 0);
    m_ready = 1'b0;

    // core_done in LOAD is ignored
    core_done = 1'b1; core_data_out = 128'h1;
    @(negedge clk);
    core_done = 1'b0;
    check("load_done_ignored_valid", m_valid, 0);
    check("load_done_ignored_busy", busy, 0);

    // timeout path
    send_word(32'hA0000000, 1'b0);
    send_word(32'hA1111111, 1'b0);
    send_word(32'hA2222222, 1'b0);
    send_word(32'hA3333333, 1'b0);
    check("to_start", core_start, 1);
    repeat (16) @(negedge clk);
    check("to_not_yet", timeout_err, 0);
    check("to_busy_before", busy, 1);
    @(negedge clk);
    check("to_err", timeout_err, 1);
    check("to_s_ready", s_ready, 1);
    check("to_busy_after", busy, 0);
    check("to_no_valid", m_valid, 0);

    // decrypt on word 0 only, then stalled drain
    send_word(32'h0F0F0F0F, 1'b1);
    check("to_err_cleared", timeout_err, 0);
    send_word(32'h1E1E1E1E, 1'b0);
    send_word(32'h2D2D2D2D, 1'b0);
    send_word(32'h3C3C3C3C, 1'b0);
    check("dec_start", core_start, 1);
    check("dec_mode_start", core_enc_dec, 1);
    check("dec_data_in", core_data_in, 128'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C);
    repeat (3) @(negedge clk);
    check("dec_mode_wait", core_enc_dec, 1);
    core_done = 1'b1; core_data_out = 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978;
    @(negedge clk);
    core_done = 1'b0; core_data_out = '0;
    exp_w[0] = 32'hFEDCBA98; exp_w[1] = 32'h76543210;
    exp_w[2] = 32'h0F1E2D3C; exp_w[3] = 32'h4B5A6978;
    hs = 0;
    for (int k = 0; k < 20 && hs < 4; k++) begin
      check("stall_valid", m_valid, 1);
      check("stall_data", m_data, exp_w[hs]);
      check("stall_last", m_last, (hs == 3) ? 1 : 0);
      m_ready = (k % 2 == 1);
      @(negedge clk);
      if (m_ready) hs++;
    end
    m_ready = 1'b0;
    check("stall_handshakes", 128'(hs), 4);
    check("stall_end_valid", m_valid, 0);
    check("stall_end_s_ready", s_ready, 1);

    // reset in the middle of loading
    send_word(32'hBAD00000, 1'b1);
    send_word(32'hBAD11111, 1'b1);
    reset = 1'b0;
    #1;
    check("midrst_s_ready", s_ready, 0);
    check("midrst_data_in", core_data_in, 0);
    check("midrst_enc_dec", core_enc_dec, 0);
    check("midrst_busy", busy, 0);
    check("midrst_m_data", m_data, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_s_ready_up", s_ready, 1);
    send_word(32'hCAFE0000, 1'b0);
    send_word(32'hCAFE1111, 1'b0);
    send_word(32'hCAFE2222, 1'b0);
    check("fresh_no_start_yet", core_start, 0);
    send_word(32'hCAFE3333, 1'b0);
    check("fresh_start", core_start, 1);
    check("fresh_data_in", core_data_in, 128'hCAFE0000_CAFE1111_CAFE2222_CAFE3333);
    check("fresh_enc_dec", core_enc_dec, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
